// File: rtl/cu_pkg.sv
// Shared definitions for the control unit: opcodes, state encoding, strobe and ALU bit indices.
// The W wait state exists only when CU_MEM_WAIT_EN is defined.
package cu_pkg;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHL  = 5'b01000;
   localparam logic [4:0] OP_ROR  = 5'b01001;
   localparam logic [4:0] OP_ROL  = 5'b01010;
   localparam logic [4:0] OP_ADDI = 5'b01011;
   localparam logic [4:0] OP_ANDI = 5'b01100;
   localparam logic [4:0] OP_ORI  = 5'b01101;
   localparam logic [4:0] OP_NEG  = 5'b01110;
   localparam logic [4:0] OP_NOT  = 5'b01111;
   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_JR   = 5'b10011;
   localparam logic [4:0] OP_NOP  = 5'b11000;
   localparam logic [4:0] OP_HALT = 5'b11001;

   typedef enum logic [3:0] {
      S_RST  = 4'd0,
      S_T0   = 4'd1,
      S_T1   = 4'd2,
      S_T2   = 4'd3,
      S_T3   = 4'd4,
      S_T4   = 4'd5,
      S_T5   = 4'd6,
      S_T6   = 4'd7,
      S_T7   = 4'd8,
      S_HALT = 4'd9
`ifdef CU_MEM_WAIT_EN
      , S_W  = 4'd10
`endif
   } state_t;

   typedef enum logic [3:0] {
      CL_RTYPE = 4'd0,
      CL_ITYPE = 4'd1,
      CL_UNARY = 4'd2,
      CL_LD    = 4'd3,
      CL_LDI   = 4'd4,
      CL_ST    = 4'd5,
      CL_BR    = 4'd6,
      CL_JR    = 4'd7,
      CL_NOP   = 4'd8,
      CL_HALT  = 4'd9
   } op_class_t;

   localparam int CTL_W = 20;
   localparam int CTL_PCOUT   = 0;
   localparam int CTL_ZLOWOUT = 1;
   localparam int CTL_MDROUT  = 2;
   localparam int CTL_COUT    = 3;
   localparam int CTL_BAOUT   = 4;
   localparam int CTL_ROUT    = 5;
   localparam int CTL_GRA     = 6;
   localparam int CTL_GRB     = 7;
   localparam int CTL_GRC     = 8;
   localparam int CTL_RIN     = 9;
   localparam int CTL_MARIN   = 10;
   localparam int CTL_ZIN     = 11;
   localparam int CTL_PCIN    = 12;
   localparam int CTL_MDRIN   = 13;
   localparam int CTL_IRIN    = 14;
   localparam int CTL_YIN     = 15;
   localparam int CTL_INCPC   = 16;
   localparam int CTL_READ    = 17;
   localparam int CTL_WRITE   = 18;
   localparam int CTL_CONIN   = 19;

   localparam int ALU_W = 10;
   localparam int ALU_ADD = 0;
   localparam int ALU_SUB = 1;
   localparam int ALU_AND = 2;
   localparam int ALU_OR  = 3;
   localparam int ALU_SHR = 4;
   localparam int ALU_SHL = 5;
   localparam int ALU_ROR = 6;
   localparam int ALU_ROL = 7;
   localparam int ALU_NEG = 8;
   localparam int ALU_NOT = 9;

   function automatic logic [ALU_W-1:0] alu_bit(input int idx);
      logic [ALU_W-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/cu_decode.sv
// Opcode classifier: maps a 5-bit opcode to its sequencing class and the ALU
// function it needs in its compute step. Unknown opcodes behave as nop.
module cu_decode
   import cu_pkg::*;
(
   input  logic [4:0]       opcode,
   output op_class_t        op_class,
   output logic [ALU_W-1:0] alu_op
);

   always_comb begin
      op_class = CL_NOP;
      alu_op   = '0;
      case (opcode)
         OP_LD:   op_class = CL_LD;
         OP_LDI:  op_class = CL_LDI;
         OP_ST:   op_class = CL_ST;
         OP_ADD:  begin op_class = CL_RTYPE; alu_op = alu_bit(ALU_ADD); end
         OP_SUB:  begin op_class = CL_RTYPE; alu_op = alu_bit(ALU_SUB); end
         OP_AND:  begin op_class = CL_RTYPE; alu_op = alu_bit(ALU_AND); end
         OP_OR:   begin op_class = CL_RTYPE; alu_op = alu_bit(ALU_OR);  end
         OP_SHR:  begin op_class = CL_RTYPE; alu_op = alu_bit(ALU_SHR); end
         OP_SHL:  begin op_class = CL_RTYPE; alu_op = alu_bit(ALU_SHL); end
         OP_ROR:  begin op_class = CL_RTYPE; alu_op = alu_bit(ALU_ROR); end
         OP_ROL:  begin op_class = CL_RTYPE; alu_op = alu_bit(ALU_ROL); end
         OP_ADDI: begin op_class = CL_ITYPE; alu_op = alu_bit(ALU_ADD); end
         OP_ANDI: begin op_class = CL_ITYPE; alu_op = alu_bit(ALU_AND); end
         OP_ORI:  begin op_class = CL_ITYPE; alu_op = alu_bit(ALU_OR);  end
         OP_NEG:  begin op_class = CL_UNARY; alu_op = alu_bit(ALU_NEG); end
         OP_NOT:  begin op_class = CL_UNARY; alu_op = alu_bit(ALU_NOT); end
         OP_BR:   op_class = CL_BR;
         OP_JR:   op_class = CL_JR;
         OP_HALT: op_class = CL_HALT;
         default: op_class = CL_NOP;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Moore sequencer for the datapath: fetch, decode and per-class execute steps.
// Define CU_MEM_WAIT_EN to insert a W wait state after every memory read.
//
// state | meaning
// RST   | held in reset, all strobes off, run high
// T0    | fetch: PC to MAR, increment PC into Z
// T1    | fetch: Z to PC, memory read into MDR
// T2    | fetch: MDR to IR; halt decided here
// T3-T7 | execute steps, content depends on the opcode class
// HALT  | stopped, run low, strobes off until reset
// W     | second read cycle (CU_MEM_WAIT_EN only)
module control_unit
   import cu_pkg::*;
(
   input  logic             clk,
   input  logic             clear,
   input  logic [31:0]      ir,
   input  logic             con_ff,
   output logic [CTL_W-1:0] ctl,
   output logic [ALU_W-1:0] alu_sel,
   output logic             run,
   output logic [3:0]       step
);

   state_t           state, state_nxt;
   op_class_t        cls_live, cls_q;
   logic [ALU_W-1:0] alu_live, alu_q;
   logic [26:0]      unused_ir;

   assign unused_ir = ir[26:0];

   cu_decode u_decode (
      .opcode   (ir[31:27]),
      .op_class (cls_live),
      .alu_op   (alu_live)
   );

   // Opcode class is captured at the T2->T3 edge so execute steps ignore later ir changes.
   always_ff @(posedge clk or negedge clear) begin
      if (!clear) begin
         state <= S_RST;
         cls_q <= CL_NOP;
         alu_q <= '0;
      end else begin
         state <= state_nxt;
         if (state == S_T2) begin
            cls_q <= cls_live;
            alu_q <= alu_live;
         end
      end
   end

`ifdef CU_MEM_WAIT_EN
   logic w_to_t7;

   always_ff @(posedge clk or negedge clear) begin
      if (!clear)
         w_to_t7 <= 1'b0;
      else if (state == S_T1)
         w_to_t7 <= 1'b0;
      else if (state == S_T6)
         w_to_t7 <= 1'b1;
   end
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_RST: state_nxt = S_T0;
         S_T0:  state_nxt = S_T1;
`ifdef CU_MEM_WAIT_EN
         S_T1:  state_nxt = S_W;
         S_W:   state_nxt = w_to_t7 ? S_T7 : S_T2;
`else
         S_T1:  state_nxt = S_T2;
`endif
         S_T2:  state_nxt = (cls_live == CL_HALT) ? S_HALT : S_T3;
         S_T3: begin
            case (cls_q)
               CL_RTYPE, CL_ITYPE, CL_UNARY,
               CL_LD, CL_LDI, CL_ST, CL_BR: state_nxt = S_T4;
               default:                     state_nxt = S_T0;
            endcase
         end
         S_T4:  state_nxt = (cls_q == CL_UNARY) ? S_T0 : S_T5;
         S_T5: begin
            case (cls_q)
               CL_LD, CL_ST, CL_BR: state_nxt = S_T6;
               default:             state_nxt = S_T0;
            endcase
         end
         S_T6: begin
            case (cls_q)
`ifdef CU_MEM_WAIT_EN
               CL_LD:   state_nxt = S_W;
`else
               CL_LD:   state_nxt = S_T7;
`endif
               CL_ST:   state_nxt = S_T7;
               default: state_nxt = S_T0;
            endcase
         end
         S_T7:   state_nxt = S_T0;
         S_HALT: state_nxt = S_HALT;
         default: state_nxt = S_RST;
      endcase
   end

   always_comb begin
      ctl     = '0;
      alu_sel = '0;
      run     = 1'b1;
      case (state)
         S_T0: begin
            ctl[CTL_PCOUT] = 1'b1; ctl[CTL_MARIN] = 1'b1;
            ctl[CTL_INCPC] = 1'b1; ctl[CTL_ZIN]   = 1'b1;
         end
         S_T1: begin
            ctl[CTL_ZLOWOUT] = 1'b1; ctl[CTL_PCIN]  = 1'b1;
            ctl[CTL_READ]    = 1'b1; ctl[CTL_MDRIN] = 1'b1;
         end
`ifdef CU_MEM_WAIT_EN
         // Both read states reduce to the same pair once PCin/Zlowout are dropped.
         S_W: begin
            ctl[CTL_READ] = 1'b1; ctl[CTL_MDRIN] = 1'b1;
         end
`endif
         S_T2: begin
            ctl[CTL_MDROUT] = 1'b1; ctl[CTL_IRIN] = 1'b1;
         end
         S_T3: begin
            case (cls_q)
               CL_RTYPE, CL_ITYPE: begin
                  ctl[CTL_GRB] = 1'b1; ctl[CTL_ROUT] = 1'b1; ctl[CTL_YIN] = 1'b1;
               end
               CL_UNARY: begin
                  ctl[CTL_GRB] = 1'b1; ctl[CTL_ROUT] = 1'b1; ctl[CTL_ZIN] = 1'b1;
                  alu_sel = alu_q;
               end
               CL_LD, CL_LDI, CL_ST: begin
                  ctl[CTL_GRB] = 1'b1; ctl[CTL_BAOUT] = 1'b1; ctl[CTL_YIN] = 1'b1;
               end
               CL_JR: begin
                  ctl[CTL_GRA] = 1'b1; ctl[CTL_ROUT] = 1'b1; ctl[CTL_PCIN] = 1'b1;
               end
               CL_BR: begin
                  ctl[CTL_GRA] = 1'b1; ctl[CTL_ROUT] = 1'b1; ctl[CTL_CONIN] = 1'b1;
               end
               default: ;
            endcase
         end
         S_T4: begin
            case (cls_q)
               CL_RTYPE: begin
                  ctl[CTL_GRC] = 1'b1; ctl[CTL_ROUT] = 1'b1; ctl[CTL_ZIN] = 1'b1;
                  alu_sel = alu_q;
               end
               CL_ITYPE: begin
                  ctl[CTL_COUT] = 1'b1; ctl[CTL_ZIN] = 1'b1;
                  alu_sel = alu_q;
               end
               CL_UNARY: begin
                  ctl[CTL_ZLOWOUT] = 1'b1; ctl[CTL_GRA] = 1'b1; ctl[CTL_RIN] = 1'b1;
               end
               CL_LD, CL_LDI, CL_ST: begin
                  ctl[CTL_COUT] = 1'b1; ctl[CTL_ZIN] = 1'b1;
                  alu_sel = alu_bit(ALU_ADD);
               end
               CL_BR: begin
                  ctl[CTL_PCOUT] = 1'b1; ctl[CTL_YIN] = 1'b1;
               end
               default: ;
            endcase
         end
         S_T5: begin
            case (cls_q)
               CL_RTYPE, CL_ITYPE, CL_LDI: begin
                  ctl[CTL_ZLOWOUT] = 1'b1; ctl[CTL_GRA] = 1'b1; ctl[CTL_RIN] = 1'b1;
               end
               CL_LD, CL_ST: begin
                  ctl[CTL_ZLOWOUT] = 1'b1; ctl[CTL_MARIN] = 1'b1;
               end
               CL_BR: begin
                  ctl[CTL_COUT] = 1'b1; ctl[CTL_ZIN] = 1'b1;
                  alu_sel = alu_bit(ALU_ADD);
               end
               default: ;
            endcase
         end
         S_T6: begin
            case (cls_q)
               CL_LD: begin
                  ctl[CTL_READ] = 1'b1; ctl[CTL_MDRIN] = 1'b1;
               end
               CL_ST: begin
                  ctl[CTL_GRA] = 1'b1; ctl[CTL_ROUT] = 1'b1; ctl[CTL_MDRIN] = 1'b1;
               end
               // Only place an input reaches the strobes: the branch is taken on con_ff.
               CL_BR: begin
                  ctl[CTL_ZLOWOUT] = con_ff; ctl[CTL_PCIN] = con_ff;
               end
               default: ;
            endcase
         end
         S_T7: begin
            case (cls_q)
               CL_LD: begin
                  ctl[CTL_MDROUT] = 1'b1; ctl[CTL_GRA] = 1'b1; ctl[CTL_RIN] = 1'b1;
               end
               CL_ST: ctl[CTL_WRITE] = 1'b1;
               default: ;
            endcase
         end
         S_HALT: run = 1'b0;
         default: ;
      endcase
   end

   assign step = state;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle expectations are queued per instruction
// and compared on the falling clock edge.
module tb_control_unit;
   import cu_pkg::*;

   logic             clk;
   logic             clear;
   logic [31:0]      ir;
   logic             con_ff;
   logic [CTL_W-1:0] ctl;
   logic [ALU_W-1:0] alu_sel;
   logic             run;
   logic [3:0]       step;

   int checks   = 0;
   int failures = 0;

   control_unit dut (
      .clk     (clk),
      .clear   (clear),
      .ir      (ir),
      .con_ff  (con_ff),
      .ctl     (ctl),
      .alu_sel (alu_sel),
      .run     (run),
      .step    (step)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [19:0] M_PCOUT   = 20'd1 << CTL_PCOUT;
   localparam logic [19:0] M_ZLOWOUT = 20'd1 << CTL_ZLOWOUT;
   localparam logic [19:0] M_MDROUT  = 20'd1 << CTL_MDROUT;
   localparam logic [19:0] M_COUT    = 20'd1 << CTL_COUT;
   localparam logic [19:0] M_BAOUT   = 20'd1 << CTL_BAOUT;
   localparam logic [19:0] M_ROUT    = 20'd1 << CTL_ROUT;
   localparam logic [19:0] M_GRA     = 20'd1 << CTL_GRA;
   localparam logic [19:0] M_GRB     = 20'd1 << CTL_GRB;
   localparam logic [19:0] M_GRC     = 20'd1 << CTL_GRC;
   localparam logic [19:0] M_RIN     = 20'd1 << CTL_RIN;
   localparam logic [19:0] M_MARIN   = 20'd1 << CTL_MARIN;
   localparam logic [19:0] M_ZIN     = 20'd1 << CTL_ZIN;
   localparam logic [19:0] M_PCIN    = 20'd1 << CTL_PCIN;
   localparam logic [19:0] M_MDRIN   = 20'd1 << CTL_MDRIN;
   localparam logic [19:0] M_IRIN    = 20'd1 << CTL_IRIN;
   localparam logic [19:0] M_YIN     = 20'd1 << CTL_YIN;
   localparam logic [19:0] M_INCPC   = 20'd1 << CTL_INCPC;
   localparam logic [19:0] M_READ    = 20'd1 << CTL_READ;
   localparam logic [19:0] M_WRITE   = 20'd1 << CTL_WRITE;
   localparam logic [19:0] M_CONIN   = 20'd1 << CTL_CONIN;

   localparam logic [9:0] A_NONE = 10'd0;
   localparam logic [9:0] A_ADD  = 10'd1 << ALU_ADD;
   localparam logic [9:0] A_OR   = 10'd1 << ALU_OR;
   localparam logic [9:0] A_ROR  = 10'd1 << ALU_ROR;
   localparam logic [9:0] A_NEG  = 10'd1 << ALU_NEG;
   localparam logic [9:0] A_NOT  = 10'd1 << ALU_NOT;

   typedef struct {
      logic [34:0] v;
      string       tag;
   } exp_t;

   exp_t sb[$];

   task automatic push(input logic [3:0] st, input logic [19:0] c, input logic [9:0] a,
                       input logic r, input string tag);
      exp_t e;
      e.v   = {st, c, a, r};
      e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic push_fetch(input string name);
      push(S_T0, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, A_NONE, 1'b1, {name, " T0"});
      push(S_T1, M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, A_NONE, 1'b1, {name, " T1"});
`ifdef CU_MEM_WAIT_EN
      push(S_W, M_READ | M_MDRIN, A_NONE, 1'b1, {name, " W"});
`endif
      push(S_T2, M_MDROUT | M_IRIN, A_NONE, 1'b1, {name, " T2"});
   endtask

   task automatic compare(input logic [34:0] obs, input logic [34:0] expv, input string tag);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed step=%0d ctl=%h alu=%h run=%b expected step=%0d ctl=%h alu=%h run=%b",
                tag, obs[34:31], obs[30:11], obs[10:1], obs[0],
                expv[34:31], expv[30:11], expv[10:1], expv[0]);
      end
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         @(negedge clk);
         e = sb.pop_front();
         compare({step, ctl, alu_sel, run}, e.v, e.tag);
      end
   endtask

   task automatic push_ld_tail(input string name);
      push(S_T5, M_ZLOWOUT | M_MARIN, A_NONE, 1'b1, {name, " T5"});
      push(S_T6, M_READ | M_MDRIN, A_NONE, 1'b1, {name, " T6"});
`ifdef CU_MEM_WAIT_EN
      push(S_W, M_READ | M_MDRIN, A_NONE, 1'b1, {name, " W"});
`endif
      push(S_T7, M_MDROUT | M_GRA | M_RIN, A_NONE, 1'b1, {name, " T7"});
   endtask

   initial begin
      clear  = 1'b1;
      ir     = 32'h0;
      con_ff = 1'b0;
      #1 clear = 1'b0;
      #1 compare({step, ctl, alu_sel, run}, {4'(S_RST), 20'd0, 10'd0, 1'b1}, "reset");
      @(negedge clk);
      clear = 1'b1;

      // ld R1,0x85
      ir = 32'h0080_0085;
      push_fetch("ld");
      push(S_T3, M_GRB | M_BAOUT | M_YIN, A_NONE, 1'b1, "ld T3");
      push(S_T4, M_COUT | M_ZIN, A_ADD, 1'b1, "ld T4");
      push_ld_tail("ld");
      drain();

      // add R3,R1,R2
      ir = 32'h1989_0000;
      push_fetch("add");
      push(S_T3, M_GRB | M_ROUT | M_YIN, A_NONE, 1'b1, "add T3");
      push(S_T4, M_GRC | M_ROUT | M_ZIN, A_ADD, 1'b1, "add T4");
      push(S_T5, M_ZLOWOUT | M_GRA | M_RIN, A_NONE, 1'b1, "add T5");
      drain();

      ir = 32'h4800_0000;
      push_fetch("ror");
      push(S_T3, M_GRB | M_ROUT | M_YIN, A_NONE, 1'b1, "ror T3");
      push(S_T4, M_GRC | M_ROUT | M_ZIN, A_ROR, 1'b1, "ror T4");
      push(S_T5, M_ZLOWOUT | M_GRA | M_RIN, A_NONE, 1'b1, "ror T5");
      drain();

      ir = 32'h5800_0000;
      push_fetch("addi");
      push(S_T3, M_GRB | M_ROUT | M_YIN, A_NONE, 1'b1, "addi T3");
      push(S_T4, M_COUT | M_ZIN, A_ADD, 1'b1, "addi T4");
      push(S_T5, M_ZLOWOUT | M_GRA | M_RIN, A_NONE, 1'b1, "addi T5");
      drain();

      ir = 32'h6800_0000;
      push_fetch("ori");
      push(S_T3, M_GRB | M_ROUT | M_YIN, A_NONE, 1'b1, "ori T3");
      push(S_T4, M_COUT | M_ZIN, A_OR, 1'b1, "ori T4");
      push(S_T5, M_ZLOWOUT | M_GRA | M_RIN, A_NONE, 1'b1, "ori T5");
      drain();

      ir = 32'h7000_0000;
      push_fetch("neg");
      push(S_T3, M_GRB | M_ROUT | M_ZIN, A_NEG, 1'b1, "neg T3");
      push(S_T4, M_ZLOWOUT | M_GRA | M_RIN, A_NONE, 1'b1, "neg T4");
      drain();

      ir = 32'h7800_0000;
      push_fetch("not");
      push(S_T3, M_GRB | M_ROUT | M_ZIN, A_NOT, 1'b1, "not T3");
      push(S_T4, M_ZLOWOUT | M_GRA | M_RIN, A_NONE, 1'b1, "not T4");
      drain();

      ir = 32'h0800_0000;
      push_fetch("ldi");
      push(S_T3, M_GRB | M_BAOUT | M_YIN, A_NONE, 1'b1, "ldi T3");
      push(S_T4, M_COUT | M_ZIN, A_ADD, 1'b1, "ldi T4");
      push(S_T5, M_ZLOWOUT | M_GRA | M_RIN, A_NONE, 1'b1, "ldi T5");
      drain();

      ir = 32'h1000_0000;
      push_fetch("st");
      push(S_T3, M_GRB | M_BAOUT | M_YIN, A_NONE, 1'b1, "st T3");
      push(S_T4, M_COUT | M_ZIN, A_ADD, 1'b1, "st T4");
      push(S_T5, M_ZLOWOUT | M_MARIN, A_NONE, 1'b1, "st T5");
      push(S_T6, M_GRA | M_ROUT | M_MDRIN, A_NONE, 1'b1, "st T6");
      push(S_T7, M_WRITE, A_NONE, 1'b1, "st T7");
      drain();

      ir = 32'h9800_0000;
      push_fetch("jr");
      push(S_T3, M_GRA | M_ROUT | M_PCIN, A_NONE, 1'b1, "jr T3");
      drain();

      // br R2, not taken then taken
      ir = 32'h9100_0000;
      con_ff = 1'b0;
      push_fetch("br0");
      push(S_T3, M_GRA | M_ROUT | M_CONIN, A_NONE, 1'b1, "br0 T3");
      push(S_T4, M_PCOUT | M_YIN, A_NONE, 1'b1, "br0 T4");
      push(S_T5, M_COUT | M_ZIN, A_ADD, 1'b1, "br0 T5");
      push(S_T6, 20'd0, A_NONE, 1'b1, "br0 T6");
      drain();

      con_ff = 1'b1;
      push_fetch("br1");
      push(S_T3, M_GRA | M_ROUT | M_CONIN, A_NONE, 1'b1, "br1 T3");
      push(S_T4, M_PCOUT | M_YIN, A_NONE, 1'b1, "br1 T4");
      push(S_T5, M_COUT | M_ZIN, A_ADD, 1'b1, "br1 T5");
      push(S_T6, M_ZLOWOUT | M_PCIN, A_NONE, 1'b1, "br1 T6");
      drain();
      con_ff = 1'b0;

      ir = 32'hC000_0000;
      push_fetch("nop");
      push(S_T3, 20'd0, A_NONE, 1'b1, "nop T3");
      drain();

      ir = 32'hA000_0000;
      push_fetch("undef");
      push(S_T3, 20'd0, A_NONE, 1'b1, "undef T3");
      drain();

      // clear asserted in the middle of ld T4
      ir = 32'h0080_0085;
      push_fetch("ldr");
      push(S_T3, M_GRB | M_BAOUT | M_YIN, A_NONE, 1'b1, "ldr T3");
      push(S_T4, M_COUT | M_ZIN, A_ADD, 1'b1, "ldr T4");
      drain();
      clear = 1'b0;
      #1 compare({step, ctl, alu_sel, run}, {4'(S_RST), 20'd0, 10'd0, 1'b1}, "async clear");
      #2 clear = 1'b1;
      push_fetch("ld2");
      push(S_T3, M_GRB | M_BAOUT | M_YIN, A_NONE, 1'b1, "ld2 T3");
      push(S_T4, M_COUT | M_ZIN, A_ADD, 1'b1, "ld2 T4");
      push_ld_tail("ld2");
      drain();

      ir = 32'hC800_0000;
      push_fetch("halt");
      for (int i = 0; i < 20; i++)
         push(S_HALT, 20'd0, A_NONE, 1'b0, $sformatf("halt %0d", i));
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
